dataram_arbiter: RTL

//  Shares the single-port data RAM (9-bit addr, 8-bit data, registered read output, 1-cycle read latency)

---
 rtl/cqpic_pkg.sv | 24 ++
 rtl/dataram_wait_timer.sv | 37 +++
 rtl/dataram_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cqpic_pkg.sv
// ============================================================================
// Package  : cqpic_pkg
// Brief    : Shared data-RAM geometry, GPR window defaults and arbiter FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cqpic_pkg;

  localparam int c_ram_aw = 9;
  localparam int c_ram_dw = 8;

  localparam logic [6:0] c_gpr_lo = 7'h0C;
  localparam logic [6:0] c_gpr_hi = 7'h4F;

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_issue  = 3'd1;
  localparam logic [2:0] c_rdwait = 3'd2;
  localparam logic [2:0] c_done   = 3'd3;
  localparam logic [2:0] c_err    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dataram_wait_timer.sv
// ============================================================================
// Module   : dataram_wait_timer
// Brief    : Saturating wait counter; flags when a blocked host has waited its last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataram_wait_timer #(
  parameter int LIMIT = 16,
  parameter int WIDTH = $clog2(LIMIT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= c_last);

endmodule

`default_nettype wire

// File: rtl/dataram_arbiter.sv
// ============================================================================
// Module   : dataram_arbiter
// Brief    : Shares the data RAM between the CPU (always wins) and a req/ack host port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataram_arbiter
  import cqpic_pkg::*;
#(
  parameter logic [6:0] GPR_LO      = c_gpr_lo,
  parameter logic [6:0] GPR_HI      = c_gpr_hi,
  parameter int         TIMEOUT     = 16,
  parameter bit         MIRROR_BANK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [c_ram_aw-1:0] cpu_addr,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [c_ram_dw-1:0] cpu_wdata,
  output logic [c_ram_dw-1:0] cpu_rdata,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [c_ram_aw-1:0] host_addr,
  input  logic [c_ram_dw-1:0] host_wdata,
  output logic                host_ack,
  output logic                host_err,
  output logic [c_ram_dw-1:0] host_rdata,
  output logic [c_ram_aw-1:0] ram_addr,
  output logic                ram_read,
  output logic                ram_write,
  output logic [c_ram_dw-1:0] ram_wdata,
  input  logic [c_ram_dw-1:0] ram_rdata
);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic                w_cpu_strobe;
  logic                w_in_window;
  logic                w_bad_write;
  logic                w_host_go;
  logic                w_expired;
  logic                r_rd_owner_host;
  logic [c_ram_dw-1:0] r_host_rdata;
  logic [c_ram_aw-1:0] w_host_addr;

  assign w_cpu_strobe = cpu_read | cpu_write;

  if (MIRROR_BANK) begin : g_mirror
    // Only BANK0 exists, so the upper banks alias onto it.
    logic w_unused_bank;
    assign w_unused_bank = ^host_addr[c_ram_aw-1:7];
    assign w_host_addr   = {2'b00, host_addr[6:0]};
  end else begin : g_no_mirror
    assign w_host_addr = host_addr;
  end

  assign w_in_window = (host_addr[6:0] >= GPR_LO) && (host_addr[6:0] <= GPR_HI);
  assign w_bad_write = host_we && !w_in_window;
  assign w_host_go   = (r_state == c_issue) && !w_cpu_strobe;

  // Grant mux: the CPU owns any cycle it strobes; the host only gets leftovers.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_wdata = cpu_wdata;
    if (w_cpu_strobe) begin
      ram_read  = cpu_read;
      ram_write = cpu_write;
    end else if (r_state == c_issue) begin
      ram_addr  = w_host_addr;
      ram_read  = !host_we;
      ram_write = host_we;
      ram_wdata = host_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (host_req) begin
          w_state_nxt = w_bad_write ? c_err : c_issue;
        end
      end
      c_issue: begin
        if (!w_cpu_strobe) begin
          w_state_nxt = host_we ? c_done : c_rdwait;
        end else if (w_expired) begin
          w_state_nxt = c_err;
        end
      end
      c_rdwait: w_state_nxt = c_done;
      c_done:   w_state_nxt = c_idle;
      c_err:    w_state_nxt = c_idle;
      default:  w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  dataram_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (reset),
    .i_clr     ((r_state == c_idle) && host_req),
    .i_en      ((r_state == c_issue) && w_cpu_strobe),
    .o_expired (w_expired)
  );

  // The RAM output is registered, so read data belongs to whoever read one cycle earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_owner_host <= 1'b0;
      r_host_rdata    <= '0;
    end else begin
      r_rd_owner_host <= w_host_go && !host_we;
      if (r_rd_owner_host) begin
        r_host_rdata <= ram_rdata;
      end
    end
  end

  assign cpu_rdata  = ram_rdata;
  assign host_rdata = r_host_rdata;
  assign host_ack   = (r_state == c_done) || (r_state == c_err);
  assign host_err   = (r_state == c_err);

endmodule

`default_nettype wire
